row_fetch_ctrl: RTL
===================

// Module: row_fetch_ctrl
// PURPOSE
//  Sequences the load of one IM_SIZE x IM_SIZE image from sample ROM into the row shift datapath, one row at a time.
//  Generates ROM addresses and shift enables; presents each completed row with a valid/ready handshake.
//  Sits between the sample ROM / row shift register and the downstream convolution engine; owns sample selection.
// PARAMETERS
//  IM_SIZE      28  pixels per row and rows per image
//  ADDR_W       10  ROM address width (must hold IM_SIZE*IM_SIZE-1)
//  SAMPLE_W     4   sample select width
//  NUM_SAMPLES  10  samples in ROM; sample_sel wraps at NUM_SAMPLES-1
//  ROM_LAT      1   ROM read latency in cycles (>=1)
// PORTS
//  clk          in   1         clock
//  rst          in   1         asynchronous reset, active-low
//  start        in   1         pulse: load the current sample's image
//  next_sample  in   1         pulse: advance sample_sel
//  row_ready    in   1         consumer accepts presented row
//  rom_en       out  1         ROM read strobe
//  rom_addr     out  ADDR_W    ROM address, row*IM_SIZE+col
//  shift_en     out  1         datapath shifts rom_data in this cycle
//  sample_sel   out  SAMPLE_W  ROM sample bank select
//  row_idx      out  5         index of row being fetched/presented
//  row_valid    out  1         full row held in datapath
//  busy         out  1         high in any state other than IDLE
//  done         out  1         one-cycle pulse after last row accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, column/shift counters 0.
//  FSM: IDLE -> FETCH -> DRAIN -> PRESENT -> (FETCH | IDLE).
//  IDLE: start=1 -> FETCH; row_idx=0, rom_addr=0.
//  FETCH: rom_en=1 for exactly IM_SIZE cycles; rom_addr increments each cycle; -> DRAIN.
//  shift_en = rom_en delayed ROM_LAT cycles (delay line).
//  DRAIN: ROM_LAT cycles until IM_SIZE shifts counted; -> PRESENT.
//  PRESENT: row_valid=1, held stable until row_valid&&row_ready; no shift_en.
//  On accept: row_idx<IM_SIZE-1 -> row_idx+1, FETCH, rom_addr continues.
//             row_idx==IM_SIZE-1 -> IDLE, done=1 one cycle, rom_addr=0.
//  Latency: start at cycle 0 -> row_valid first high at cycle 1+IM_SIZE+ROM_LAT.
//  start while busy: ignored. row_ready outside PRESENT: ignored.
//  next_sample in IDLE: sample_sel+1, wraps NUM_SAMPLES-1 -> 0.
//  next_sample while busy: latched (one pending max), applied on return to IDLE.
//  start and next_sample same cycle in IDLE: sample_sel increments, then FETCH runs on the new sample.
//  rst low mid-operation: immediate return to reset values; pending next_sample dropped.
// CONFIGURATION
//  ROW_FETCH_PERF_EN defined: adds out port stall_cnt[15:0].
//    Counts PRESENT cycles with row_ready=0; saturates at 16'hFFFF; cleared by reset and on start.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  cnn_pkg: IM_SIZE, NUM_SAMPLES, state encodings (IDLE/FETCH/DRAIN/PRESENT), ROM address width.
//  Sub-module rom_lat_pipe: ROM_LAT-deep 1-bit delay line producing shift_en from rom_en.
//  FSM, column counter, row counter, sample register, pending flag in top.
// TESTING
//  Reset, ROM_LAT=1, start at c0, row_ready=1 -> rom_addr 0..27 at c1..c28; row_valid at c30.
//  Full image, row_ready=1 -> 784 rom_en and 784 shift_en pulses; done pulse after row 27; ends IDLE.
//  row_ready=0 for 5 cycles in PRESENT -> row_valid held; no rom_en; stall_cnt=5 with macro.
//  next_sample x10 in IDLE from 0 -> sample_sel 1..9, then 0.
//  next_sample at row 3 -> sample_sel unchanged until done; increments in next IDLE cycle.
//  rst low during FETCH row 5 -> all outputs 0 that cycle; next start fetches from rom_addr 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the image row fetch path: image geometry,
// sample bank count, ROM address width and the row fetch FSM encoding.
package cnn_pkg;

    localparam int IM_SIZE     = 28;
    localparam int NUM_SAMPLES = 10;
    localparam int ADDR_W      = 10;
    localparam int SAMPLE_W    = 4;
    localparam int ROW_W       = 5;
    localparam int COL_W       = $clog2(IM_SIZE);
    localparam int ROM_LAT_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    // Next sample bank, wrapping after the last stored sample.
    function automatic logic [SAMPLE_W-1:0] sample_inc(input logic [SAMPLE_W-1:0] s);
        if (s == SAMPLE_W'(NUM_SAMPLES - 1)) begin
            return '0;
        end
        return s + SAMPLE_W'(1);
    endfunction

endpackage

// File: rtl/rom_lat_pipe.sv
// Fixed-depth 1-bit delay line matching the ROM read latency, so the
// datapath shift strobe lines up with the data returned for each read.
module rom_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [LAT-1:0] pipe_q;

    generate
        if (LAT == 1) begin : g_single
            // Single-stage delay.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= d_i;
                end
            end
        end else begin : g_multi
            // Multi-stage shift toward the output bit.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= {pipe_q[LAT-2:0], d_i};
                end
            end
        end
    endgenerate

    assign q_o = pipe_q[LAT-1];

endmodule

// File: rtl/row_fetch_ctrl.sv
// Row fetch controller: walks one IM_SIZE x IM_SIZE image out of the sample
// ROM a row at a time, drives the row shift datapath and hands each full row
// to the convolution engine over a valid/ready handshake. Also owns the
// sample bank selection, deferring sample changes requested mid-image.
// Optional build macro: ROW_FETCH_PERF_EN adds stall_cnt_o, a saturating
// count of PRESENT cycles in which the consumer was not ready.
module row_fetch_ctrl
    import cnn_pkg::*;
#(
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                next_sample_i,
    input  logic                row_ready_i,
    output logic                rom_en_o,
    output logic [ADDR_W-1:0]   rom_addr_o,
    output logic                shift_en_o,
    output logic [SAMPLE_W-1:0] sample_sel_o,
    output logic [ROW_W-1:0]    row_idx_o,
    output logic                row_valid_o,
    output logic                busy_o,
    output logic                done_o
`ifdef ROW_FETCH_PERF_EN
    ,
    output logic [15:0]         stall_cnt_o
`endif
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IM_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IM_SIZE - 1);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [COL_W-1:0]    shift_cnt_q, shift_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                pending_q, pending_d;
    logic                done_q, done_d;

    logic                rom_en;
    logic                shift_en;
    logic                row_accept;
    logic                last_row;
    logic                start_ok;

    assign start_ok   = (state_q == ST_IDLE) && start_i;
    assign row_accept = (state_q == ST_PRESENT) && row_ready_i;
    assign last_row   = (row_q == ROW_LAST);

    // Align the shift strobe with ROM read data.
    rom_lat_pipe #(
        .LAT (ROM_LAT)
    ) u_lat_pipe (
        .clk (clk),
        .rst (rst),
        .d_i (rom_en),
        .q_o (shift_en)
    );

    // FSM next state and state-decoded strobes.
    always_comb begin
        state_d     = state_q;
        rom_en      = 1'b0;
        row_valid_o = 1'b0;
        busy_o      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rom_en = 1'b1;
                if (col_q == COL_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wait for the last in-flight ROM word to be shifted in.
                if (shift_en && (shift_cnt_q == COL_LAST)) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                row_valid_o = 1'b1;
                if (row_ready_i) begin
                    state_d = last_row ? ST_IDLE : ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Column, shift, address, row, sample and done next-state logic.
    always_comb begin
        col_d       = col_q;
        shift_cnt_d = shift_cnt_q;
        addr_d      = addr_q;
        row_d       = row_q;
        sample_d    = sample_q;
        pending_d   = pending_q;
        done_d      = 1'b0;

        if (state_q == ST_FETCH) begin
            addr_d = addr_q + ADDR_W'(1);
            col_d  = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        end

        if (shift_en) begin
            shift_cnt_d = (shift_cnt_q == COL_LAST) ? '0 : shift_cnt_q + COL_W'(1);
        end

        if (start_ok) begin
            row_d       = '0;
            addr_d      = '0;
            col_d       = '0;
            shift_cnt_d = '0;
        end

        if (row_accept) begin
            if (last_row) begin
                addr_d = '0;
                done_d = 1'b1;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end

        // A sample change requested while busy is held and applied in IDLE;
        // in IDLE it takes effect before a same-cycle start begins fetching.
        if (state_q == ST_IDLE) begin
            if (next_sample_i || pending_q) begin
                sample_d = sample_inc(sample_q);
            end
            pending_d = 1'b0;
        end else if (next_sample_i) begin
            pending_d = 1'b1;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            shift_cnt_q <= '0;
            addr_q      <= '0;
            row_q       <= '0;
            sample_q    <= '0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            shift_cnt_q <= shift_cnt_d;
            addr_q      <= addr_d;
            row_q       <= row_d;
            sample_q    <= sample_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
        end
    end

    assign rom_en_o     = rom_en;
    assign rom_addr_o   = addr_q;
    assign shift_en_o   = shift_en;
    assign sample_sel_o = sample_q;
    assign row_idx_o    = row_q;
    assign done_o       = done_q;

`ifdef ROW_FETCH_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Consumer back-pressure counter, restarted with each image.
    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if ((state_q == ST_PRESENT) && !row_ready_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule
